bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Memory-mapped countdown timer; the responder end of the CPU data bus.
- Decodes the CPU's address, write-data and write-enable outputs, and returns read data to the CPU read-data input.
- Its interrupt output drives one bit of the CPU hardware-interrupt vector.
- Three word registers: CTRL, PRESET, COUNT. Two modes: one-shot and auto-reload.

Parameters:
BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window. BASE_ADDR[3:0] must be 0.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
addr  in  32  CPU data address (M-stage ALU result)
wdata  in  32  CPU store data
we  in  1  CPU store strobe (word store)
rdata  out  32  read data to CPU; combinational
irq  out  1  interrupt request; connects to one HWInt bit

Behaviour:
- Address decode
  - hit = (addr[31:4]==BASE_ADDR[31:4]) && (addr[3:2]!=2'b11); addr[1:0] ignored.
  - Offsets: 0x0 CTRL (rw), 0x4 PRESET (rw), 0x8 COUNT (read-only).
- rdata (combinational, same cycle as addr)
  - CTRL reads {28'b0, im, mode[1:0], en}; PRESET and COUNT read their values.
  - Non-hit or offset 0xC reads 32'h0.
- Writes (when we && hit, take effect at the edge)
  - CTRL: en<=wdata[0], mode<=wdata[2:1], im<=wdata[3]; irq_pend<=0. Bits [31:4] discarded.
  - PRESET: preset<=wdata; irq_pend<=0.
  - COUNT: ignored.
  - A bus write wins over any same-edge FSM update of the same field.
- irq = irq_pend & im, from registers only. Mode values 2 and 3 behave as mode 0.
- FSM states: IDLE, LOAD, CNT, INT. All transitions use registered en/mode/preset/count values.
  - IDLE: en=1 -> LOAD.
  - LOAD: count<=preset -> CNT.
  - CNT:
    - en=0 -> IDLE, count holds.
    - count>1: count<=count-1.
    - count==1: count<=0, irq_pend<=1 -> INT.
    - count==0 (preset 0): irq_pend<=1 -> INT.
  - INT, mode 1 (auto-reload): irq_pend<=0 -> LOAD.
  - INT, mode 0 (one-shot): en<=0 -> IDLE. irq_pend holds until a CTRL/PRESET write or reset.
- A write to PRESET while in CNT does not reload; the new value applies at the next LOAD.
- Timing, with CTRL written at edge T and PRESET=N>=1:
  - LOAD after T+1; COUNT=N after T+2; COUNT=N-k after T+2+k.
  - irq high after T+2+N.
  - Mode 1: irq is a one-cycle pulse, period N+2 cycles.
- Reset (reset=0 at an edge, including mid-count or in INT):
  - state<=IDLE; en, mode, im, preset, count, irq_pend <= 0.
  - irq=0 and all reads return 0 in the cycle after.
- count is 32-bit unsigned and never wraps below 0.

Test Plan:
1. Reset with reset=0 for 2 cycles, then read 0x7F00/0x7F04/0x7F08 -> each 0; irq=0.
2. Write PRESET=5 then CTRL=0x9 (en=1, mode 0, im=1) at edge T -> COUNT reads 5 after T+2, 1 after T+6; irq=1 after T+7; CTRL reads 0x8 after T+8; irq stays 1 for 20 idle cycles; write CTRL=0x8 -> irq=0 next cycle.
3. PRESET=3, CTRL=0xB (mode 1, im=1) -> irq one-cycle pulses every 5 cycles, 4 pulses over 20 cycles; COUNT sequence 3,2,1,0,(INT),3...
4. Same as 2 with im=0 (CTRL=0x1) -> irq never rises; the FSM still reaches IDLE and CTRL reads 0x0. Write CTRL=0x8 -> irq stays 0 (pending cleared).
5. Mid-count CTRL=0x0 at COUNT=7 -> COUNT holds 7 and irq stays 0. Mid-count reset=0 -> all reads 0 next cycle and the FSM stays IDLE.
6. Edge cases:
   - Write 0x7F08 with 0xFFFF -> COUNT unchanged.
   - Read 0x7F0C or 0x7E00 -> 0.
   - PRESET=0 with en=1 -> irq one cycle after LOAD+CNT (after T+3).
   - CTRL write at the INT-state edge in mode 0 -> the written en value persists.

Source files
------------

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation, and an interrupt request for one HWInt bit.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;
    localparam logic [1:0] MODE_AUTO  = 2'd1;

    state_t      state_reg, state_next;
    logic        en_reg, en_next;
    logic [1:0]  mode_reg, mode_next;
    logic        im_reg, im_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_pend_reg, irq_pend_next;

    logic        hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_byte_offset;

    // Byte lane bits are don't-care: only word accesses exist on this bus.
    assign unused_byte_offset = ^addr[1:0];

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr_ctrl   = we && hit && (addr[3:2] == OFF_CTRL);
    assign wr_preset = we && hit && (addr[3:2] == OFF_PRESET);

    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (addr[3:2])
                OFF_CTRL:   rdata = {28'b0, im_reg, mode_reg, en_reg};
                OFF_PRESET: rdata = preset_reg;
                OFF_COUNT:  rdata = count_reg;
                default:    rdata = 32'h0;
            endcase
        end
    end

    assign irq = irq_pend_reg & im_reg;

    always_comb begin
        state_next    = state_reg;
        en_next       = en_reg;
        mode_next     = mode_reg;
        im_next       = im_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        irq_pend_next = irq_pend_reg;

        case (state_reg)
            IDLE: begin
                if (en_reg) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset_reg;
                state_next = CNT;
            end
            CNT: begin
                if (!en_reg) begin
                    state_next = IDLE;
                end else if (count_reg > 32'd1) begin
                    count_next = count_reg - 32'd1;
                end else begin
                    // Covers both the final tick (1 -> 0) and a zero preset.
                    count_next    = 32'd0;
                    irq_pend_next = 1'b1;
                    state_next    = INT;
                end
            end
            INT: begin
                if (mode_reg == MODE_AUTO) begin
                    irq_pend_next = 1'b0;
                    state_next    = LOAD;
                end else begin
                    en_next    = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Bus writes are applied last so they override same-edge FSM updates.
        if (wr_ctrl) begin
            en_next       = wdata[0];
            mode_next     = wdata[2:1];
            im_next       = wdata[3];
            irq_pend_next = 1'b0;
        end
        if (wr_preset) begin
            preset_next   = wdata;
            irq_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            en_reg       <= 1'b0;
            mode_reg     <= 2'd0;
            im_reg       <= 1'b0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            en_reg       <= en_next;
            mode_reg     <= mode_next;
            im_reg       <= im_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_pend_reg <= irq_pend_next;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: a deadline-based timer model is checked against the DUT
// every cycle, plus hand-computed literal expectations at the key timing points.
module tb_bus_timer;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Model: a running countdown is described by its load edge and load value;
    // the count is derived arithmetically from the elapsed edge count.
    longint      cyc = 0;
    logic        m_en, m_im, m_pend;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_frozen;
    bit          m_loading, m_counting, m_fired;
    longint      m_t0, m_load_val;

    function automatic logic [31:0] m_count();
        longint el;
        if (!m_counting) return m_frozen;
        el = cyc - m_t0;
        if (m_load_val > el) return 32'(m_load_val - el);
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'b00:   return {28'b0, m_im, m_mode, m_en};
            2'b01:   return m_preset;
            2'b10:   return m_count();
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_pend & m_im;
    endfunction

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic rst_n);
        logic [31:0] held;
        longint      span;
        held = m_count();
        cyc++;
        if (!rst_n) begin
            m_en = 0; m_im = 0; m_pend = 0; m_mode = 0;
            m_preset = 0; m_frozen = 0;
            m_loading = 0; m_counting = 0; m_fired = 0;
            m_t0 = 0; m_load_val = 0;
            return;
        end
        if (m_fired) begin
            m_fired = 0;
            if (m_mode == 2'd1) begin
                m_pend = 0;
                m_loading = 1;
            end else begin
                m_en = 0;
            end
        end else if (m_loading) begin
            m_loading  = 0;
            m_counting = 1;
            m_t0       = cyc;
            m_load_val = longint'(m_preset);
        end else if (m_counting) begin
            span = (m_load_val == 0) ? 1 : m_load_val;
            if (!m_en) begin
                m_frozen   = held;
                m_counting = 0;
            end else if (cyc - m_t0 >= span) begin
                m_counting = 0;
                m_frozen   = 0;
                m_pend     = 1;
                m_fired    = 1;
            end
        end else if (m_en) begin
            m_loading = 1;
        end
        if (w && a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'b00) begin
                m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_pend = 0;
            end else if (a[3:2] == 2'b01) begin
                m_preset = d; m_pend = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("rdata_vs_model", rdata, model_read(addr));
            check("irq_vs_model", {31'b0, irq}, {31'b0, model_irq()});
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr = a; wdata = d; we = w;
        @(posedge clk);
        model_edge(a, d, w, reset);
        #1;
        addr = A_CNT; wdata = 32'h0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(A_CNT, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(a, d, 1'b1);
        $display("write %h <= %h", a, d);
    endtask

    task automatic expect_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check({name, "_dut"}, rdata, exp);
        check({name, "_model"}, model_read(a), exp);
        $display("read  %h -> %h (expect %h)", a, rdata, exp);
        addr = A_CNT;
    endtask

    task automatic expect_irq(input string name, input logic exp);
        check({name, "_dut"}, {31'b0, irq}, {31'b0, exp});
        check({name, "_model"}, {31'b0, model_irq()}, {31'b0, exp});
        $display("irq   = %0b (expect %0b)", irq, exp);
    endtask

    logic [31:0] seq3 [5];
    int pulses;

    initial begin
        reset = 1'b0; addr = A_CNT; wdata = 32'h0; we = 1'b0;
        seq3[0] = 32'd0; seq3[1] = 32'd0; seq3[2] = 32'd3; seq3[3] = 32'd2; seq3[4] = 32'd1;

        // 1: reset
        idle(2);
        reset = 1'b1;
        cmp_on = 1'b1;
        expect_reg("rst_ctrl", A_CTRL, 32'h0);
        expect_reg("rst_preset", A_PRE, 32'h0);
        expect_reg("rst_count", A_CNT, 32'h0);
        expect_irq("rst_irq", 1'b0);

        // 2: one-shot with interrupt enabled
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        idle(2);
        expect_reg("os_count_n", A_CNT, 32'd5);
        idle(4);
        expect_reg("os_count_1", A_CNT, 32'd1);
        expect_irq("os_irq_pre", 1'b0);
        idle(1);
        expect_irq("os_irq_rise", 1'b1);
        idle(1);
        expect_reg("os_ctrl_en_clr", A_CTRL, 32'h8);
        idle(20);
        expect_irq("os_irq_held", 1'b1);
        wr(A_CTRL, 32'h8);
        expect_irq("os_irq_cleared", 1'b0);

        // 3: auto-reload, period N+2
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            expect_reg("ar_count", A_CNT, seq3[i % 5]);
            expect_irq("ar_irq", (i % 5) == 0);
            if (irq) pulses++;
        end
        check("ar_pulses", pulses, 32'd4);
        wr(A_CTRL, 32'h0);
        idle(4);

        // 4: one-shot with interrupt masked
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h1);
        idle(8);
        expect_reg("mask_ctrl", A_CTRL, 32'h0);
        expect_irq("mask_irq", 1'b0);
        wr(A_CTRL, 32'h8);
        idle(1);
        expect_irq("mask_pend_clr", 1'b0);

        // 5: mid-count disable, read-only COUNT, decode holes, mid-count reset
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h1);
        idle(4);
        expect_reg("mid_count_8", A_CNT, 32'd8);
        wr(A_CTRL, 32'h0);
        idle(5);
        expect_reg("mid_hold_7", A_CNT, 32'd7);
        expect_irq("mid_irq", 1'b0);
        wr(A_CNT, 32'hFFFF);
        expect_reg("count_ro", A_CNT, 32'd7);
        expect_reg("hole_0c", BASE + 32'hC, 32'h0);
        expect_reg("miss_7e00", 32'h0000_7E00, 32'h0);
        expect_reg("byte_off", BASE + 32'h5, 32'd10);
        wr(A_CTRL, 32'h9);
        idle(4);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        expect_reg("mrst_ctrl", A_CTRL, 32'h0);
        expect_reg("mrst_preset", A_PRE, 32'h0);
        expect_reg("mrst_count", A_CNT, 32'h0);
        expect_irq("mrst_irq", 1'b0);
        idle(5);
        expect_reg("mrst_idle", A_CNT, 32'h0);

        // 6: zero preset, CTRL write in INT, mode 2 as one-shot
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        idle(2);
        expect_irq("p0_irq_early", 1'b0);
        idle(1);
        expect_irq("p0_irq", 1'b1);
        wr(A_CTRL, 32'h9);
        expect_reg("int_wr_en", A_CTRL, 32'h9);
        expect_irq("int_wr_irq", 1'b0);
        idle(3);
        expect_irq("int_wr_refire", 1'b1);
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h5);
        idle(5);
        expect_reg("mode2_oneshot", A_CTRL, 32'h4);
        idle(3);

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
